// File: rtl/mc_control_unit_if.sv
// Cache-side handshake bundle for mc_control_unit: fetch/data requests and their hits.
interface mc_control_unit_if;
  logic [31:0] instr;
  logic        ihit;
  logic        dhit;
  logic        iREN;
  logic        dREN;
  logic        dWEN;

  modport master (input instr, ihit, dhit, output iREN, dREN, dWEN);
  modport slave  (output instr, ihit, dhit, input iREN, dREN, dWEN);
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT with cache handshakes.
// Optional memory-wait watchdog is compiled in when MC_CU_WATCHDOG_EN is defined.
module mc_control_unit #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  mc_control_unit_if.master cache,
  input  logic              alu_zero,
  output logic              pc_wen,
  output logic [1:0]        pc_src,
  output logic [31:0]       ir,
  output logic              regwr,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic [1:0]        alu_src,
  output logic [3:0]        alu_op,
  output logic              extop,
  output logic              halt,
  output logic              err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_RALU = 4'd1,
    C_JR   = 4'd2,
    C_IALU = 4'd3,
    C_LW   = 4'd4,
    C_SW   = 4'd5,
    C_BEQ  = 4'd6,
    C_BNE  = 4'd7,
    C_J    = 4'd8,
    C_JAL  = 4'd9,
    C_HALT = 4'd10
  } cls_t;

  state_t      state_r;
  logic [31:0] ir_r;
  logic        halt_r;

  cls_t        cls_s;
  aluop_t      alu_op_s;
  logic [1:0]  alu_src_s;
  logic        extop_s;
  logic [1:0]  regdst_s;
  logic [1:0]  memtoreg_s;
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;

  logic        iren_s;
  logic        dren_s;
  logic        dwen_s;
  logic        pc_wen_s;
  logic [1:0]  pc_src_s;
  logic        regwr_s;
  logic        waiting_s;
  logic        wd_trip_s;

  assign opcode_s = ir_r[31:26];
  assign funct_s  = ir_r[5:0];

  // Instruction decode from the latched IR; selects stay stable while IR is held.
  always_comb begin
    cls_s      = C_NOP;
    alu_op_s   = ALU_ADD;
    alu_src_s  = 2'd0;
    extop_s    = 1'b0;
    regdst_s   = 2'd0;
    memtoreg_s = 2'd0;
    case (opcode_s)
      6'h00: begin
        cls_s    = C_RALU;
        regdst_s = 2'd1;
        case (funct_s)
          6'h00:   alu_op_s = ALU_SLL;
          6'h02:   alu_op_s = ALU_SRL;
          6'h21:   alu_op_s = ALU_ADD;
          6'h23:   alu_op_s = ALU_SUB;
          6'h24:   alu_op_s = ALU_AND;
          6'h25:   alu_op_s = ALU_OR;
          6'h26:   alu_op_s = ALU_XOR;
          6'h27:   alu_op_s = ALU_NOR;
          6'h2A:   alu_op_s = ALU_SLT;
          6'h2B:   alu_op_s = ALU_SLTU;
          6'h08:   cls_s    = C_JR;
          default: cls_s    = C_NOP;
        endcase
      end
      6'h09: begin cls_s = C_IALU; alu_src_s = 2'd1; extop_s = 1'b1; end
      6'h0A: begin cls_s = C_IALU; alu_src_s = 2'd1; extop_s = 1'b1; alu_op_s = ALU_SLT; end
      6'h0B: begin cls_s = C_IALU; alu_src_s = 2'd1; extop_s = 1'b1; alu_op_s = ALU_SLTU; end
      6'h0C: begin cls_s = C_IALU; alu_src_s = 2'd1; alu_op_s = ALU_AND; end
      6'h0D: begin cls_s = C_IALU; alu_src_s = 2'd1; alu_op_s = ALU_OR; end
      6'h0E: begin cls_s = C_IALU; alu_src_s = 2'd1; alu_op_s = ALU_XOR; end
      // LUI adds the shifted immediate to rs, which the encoding fixes at $0.
      6'h0F: begin cls_s = C_IALU; alu_src_s = 2'd2; end
      6'h23: begin cls_s = C_LW; alu_src_s = 2'd1; extop_s = 1'b1; memtoreg_s = 2'd1; end
      6'h2B: begin cls_s = C_SW; alu_src_s = 2'd1; extop_s = 1'b1; end
      6'h04: begin cls_s = C_BEQ; extop_s = 1'b1; alu_op_s = ALU_SUB; end
      6'h05: begin cls_s = C_BNE; extop_s = 1'b1; alu_op_s = ALU_SUB; end
      6'h02: cls_s = C_J;
      6'h03: begin cls_s = C_JAL; regdst_s = 2'd2; memtoreg_s = 2'd2; end
      6'h3F: cls_s = C_HALT;
      default: cls_s = C_NOP;
    endcase
  end

  assign waiting_s = ((state_r == FETCH) && !cache.ihit) ||
                     ((state_r == MEM)   && !cache.dhit);

`ifdef MC_CU_WATCHDOG_EN
  logic [CNT_W-1:0] wait_cnt_r;
  logic             err_r;

  assign wd_trip_s = waiting_s && (wait_cnt_r == CNT_W'(WAIT_MAX - 1));

  // Wait counter: counts consecutive hit-less FETCH/MEM cycles, cleared on any state change.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (waiting_s && !wd_trip_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      err_r <= err_r | wd_trip_s;
    end
  end

  assign err = err_r;
`else
  logic [CNT_W-1:0] wait_unused_s;

  assign wait_unused_s = CNT_W'(WAIT_MAX) ^ {CNT_W{waiting_s}};
  assign wd_trip_s     = 1'b0;
  assign err           = 1'b0;
`endif

  // Sequencer state, instruction register and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= FETCH;
      ir_r    <= 32'h0000_0000;
      halt_r  <= 1'b0;
    end else if (wd_trip_s) begin
      state_r <= HALT;
      halt_r  <= 1'b1;
    end else begin
      case (state_r)
        FETCH: begin
          if (cache.ihit) begin
            ir_r    <= cache.instr;
            state_r <= DECODE;
          end
        end
        DECODE: begin
          if (cls_s == C_HALT) begin
            state_r <= HALT;
            halt_r  <= 1'b1;
          end else begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          case (cls_s)
            C_RALU, C_IALU, C_JAL: state_r <= WB;
            C_LW, C_SW:            state_r <= MEM;
            default:               state_r <= FETCH;
          endcase
        end
        MEM: begin
          if (cache.dhit) begin
            state_r <= (cls_s == C_LW) ? WB : FETCH;
          end
        end
        WB:      state_r <= FETCH;
        HALT:    state_r <= HALT;
        default: state_r <= FETCH;
      endcase
    end
  end

  // Per-cycle strobes from state, IR class and the hit/zero inputs.
  always_comb begin
    iren_s   = 1'b0;
    dren_s   = 1'b0;
    dwen_s   = 1'b0;
    pc_wen_s = 1'b0;
    pc_src_s = 2'd0;
    regwr_s  = 1'b0;
    case (state_r)
      FETCH: begin
        iren_s   = 1'b1;
        pc_wen_s = cache.ihit;
      end
      EXEC: begin
        case (cls_s)
          C_JR:       begin pc_wen_s = 1'b1; pc_src_s = 2'd3; end
          C_J, C_JAL: begin pc_wen_s = 1'b1; pc_src_s = 2'd2; end
          C_BEQ:      begin pc_wen_s = alu_zero;  pc_src_s = alu_zero ? 2'd1 : 2'd0; end
          C_BNE:      begin pc_wen_s = !alu_zero; pc_src_s = alu_zero ? 2'd0 : 2'd1; end
          default:    pc_wen_s = 1'b0;
        endcase
      end
      MEM: begin
        dren_s = (cls_s == C_LW);
        dwen_s = (cls_s == C_SW);
      end
      WB:      regwr_s = 1'b1;
      default: iren_s  = 1'b0;
    endcase
  end

  assign cache.iREN = iren_s;
  assign cache.dREN = dren_s;
  assign cache.dWEN = dwen_s;
  assign pc_wen     = pc_wen_s;
  assign pc_src     = pc_src_s;
  assign regwr      = regwr_s;
  assign ir         = ir_r;
  assign regdst     = regdst_s;
  assign memtoreg   = memtoreg_s;
  assign alu_src    = alu_src_s;
  assign alu_op     = alu_op_s;
  assign extop      = extop_s;
  assign halt       = halt_r;
  assign state      = state_r;

endmodule
